// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: word sizes, fetch FSM states, fetch queue entry
package cpu_pkg;

    localparam int WORD_W    = 32;
    localparam int INS_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] ins;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry circular prefetch FIFO; flush beats push/pop
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstd,
    input  logic                flush,
    input  logic                push,
    input  fetch_entry_t        push_data,
    input  logic                pop,
    output logic [CW-1:0]       count,
    output fetch_entry_t        head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t        mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of 2.
    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end; optional FETCH_STALL_CNT_EN adds stall_cnt
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h00000000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              ins_valid,
    output logic [WORD_W-1:0] ins,
    output logic [WORD_W-1:0] ins_pc,
    output logic [WORD_W-1:0] nextpc,
    input  logic              ins_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t      state, state_nxt;
    logic [WORD_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [WORD_W-1:0] addr_nxt;
    logic              req_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic              ack, push, pop, can_issue;
    fetch_entry_t      head, push_data;

    // An ack only counts against an outstanding request; redirect kills both push and pop.
    assign ack       = imem_ack && imem_req;
    assign push      = (state == S_WAIT) && ack && !redirect;
    assign pop       = ins_valid && ins_ready && !redirect;
    assign count_nxt = redirect ? '0 : (count + CW'(push) - CW'(pop));
    assign can_issue = !redirect && (count_nxt < CW'(DEPTH));
    assign push_data = '{ins: imem_rdata, pc: imem_addr};

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
        .clk       (clk),
        .rstd      (rstd),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign ins_valid = (count != '0);
    assign ins       = head.ins;
    assign ins_pc    = head.pc;
    assign nextpc    = head.pc + WORD_W'(INS_BYTES);

    // Next-state, next fetch address and request control.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = imem_addr;
        req_nxt      = imem_req;
        case (state)
            S_IDLE: begin
                if (can_issue) begin
                    addr_nxt     = fetch_pc;
                    fetch_pc_nxt = fetch_pc + WORD_W'(INS_BYTES);
                    req_nxt      = 1'b1;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    if (ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_FLUSH;
                    end
                end else if (ack) begin
                    if (can_issue) begin
                        addr_nxt     = fetch_pc;
                        fetch_pc_nxt = fetch_pc + WORD_W'(INS_BYTES);
                    end else begin
                        req_nxt   = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
        if (redirect) begin
            fetch_pc_nxt = redirect_pc & ~WORD_W'(3);
        end
    end

    // FSM, fetch PC and the registered memory request.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles where decode wanted an instruction but none was ready.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            stall_cnt <= '0;
        end else if (ins_ready && !ins_valid && !redirect && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
